v_hier_subdeser: RTL and testbench
==================================

Name: v_hier_subdeser

Overview:
- Downstream consumer of the v_hier_subsub single-bit output `q`.
- Collects qualified serial bits, LSB first, into WIDTH-bit words.
- Queues completed words in a DEPTH-entry FIFO and presents them on a valid/ready word interface.
- Sits one hierarchy level above the bit source and feeds word-level logic in v_hier_sub.

Parameters:
- WIDTH, 8: data bits per word; must be ≥2.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  qualifies bit_in this cycle.
- bit_in  input  1  serial data bit; connected to v_hier_subsub `q`.
- frame_start  input  1  marks bit_in as bit 0 of a new word; ignored unless bit_valid=1.
- word_valid  output  1  FIFO head holds a word.
- word_ready  input  1  consumer accepts the head word.
- word_data  output  WIDTH  FIFO head word; bit 0 = first received bit.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- parity_err  output  1  one-cycle pulse on parity failure; constant 0 when the optional feature is out.

Behaviour:
- Reset: a synchronous rst=1 clears everything: state=IDLE, bit counter=0, shift register=0, FIFO pointers=0.
  - Outputs after reset: word_valid=0, word_data=0, level=0, overflow=0, parity_err=0.
  - A reset in the middle of a word or with the FIFO non-empty discards all partial and queued data.
  - overflow clears only on rst.
- State IDLE:
  - bit_valid and frame_start=0: ignored.
  - bit_valid and frame_start=1: load bit_in as bit 0, counter=1, go to SHIFT.
- State SHIFT, on each bit_valid:
  - Write bit_in into position counter, then increment the counter.
  - On the WIDTH-th bit the word completes. Without the feature: push to the FIFO, counter=0, stay in SHIFT (back-to-back words need no new frame_start). With the feature: go to PAR.
  - frame_start=1 with bit_valid in SHIFT (or PAR) resyncs: the partial word is discarded silently and the current bit becomes bit 0, counter=1, state SHIFT. Nothing is pushed and overflow is not set.
  - bit_valid=0: hold all state.
- Push latency: a word completing on the clock edge that samples bit N is visible as word_valid=1 (if the FIFO was empty) in the cycle after that edge. word_data for that word appears at the same time.
- FIFO read side:
  - word_data shows the head entry; it is registered storage, no combinational path from bit_in.
  - word_valid = (level != 0).
  - Pop occurs when word_valid && word_ready.
  - While word_valid=1 and word_ready=0, word_data is held stable.
- FIFO full:
  - A push with level==DEPTH and no pop in the same cycle drops the word and sets overflow=1.
  - A push with level==DEPTH and a pop in the same cycle succeeds; level stays DEPTH.
- FIFO empty: word_ready has no effect; level stays 0.
- Simultaneous push and pop when not full: level unchanged.
- Pointers wrap modulo DEPTH.
- level increments on push only, decrements on pop only.

Optional Feature:
- Macro: V_HIER_SUBDESER_PARITY_EN
- Defined:
  - After WIDTH data bits the block enters state PAR.
  - The next valid bit is a parity bit; even parity over data plus parity is required.
  - Parity correct: push the word, go to SHIFT with counter=0.
  - Parity incorrect: drop the word, pulse parity_err=1 for exactly one cycle (the cycle after the parity bit is sampled), go to SHIFT with counter=0.
  - frame_start in PAR resyncs as in SHIFT, with no parity check.
- Undefined: no PAR state, no parity bit; parity_err is tied to 0.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset with X-free inputs: all outputs 0 the cycle after rst; hold rst for 3 cycles with bit_valid=1 and frame_start=1 -> no word pushed.
2. frame_start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles with word_ready=1 -> word_valid=1 with word_data=0xA5 one cycle after the 8th bit, popped that cycle; level returns to 0.
3. Five back-to-back words 0x01,0x02,0x03,0x04,0x05 with word_ready=0 -> level=4, 0x05 dropped, overflow=1. Then word_ready=1 -> 0x01..0x04 drain in order, overflow stays 1.
4. FIFO at level=4 and word_ready=1 on the cycle a 6th word (0x06) completes -> push accepted, level stays 4, overflow unchanged, last entry is 0x06.
5. Send 5 bits, then frame_start with bits for 0x3C -> only 0x3C emerges, no overflow.
6. With the macro defined: 0xA5 followed by parity bit 0 -> word 0xA5 pushed. 0xA5 followed by parity bit 1 -> no push, parity_err pulses exactly 1 cycle, level unchanged.

Source files
------------

// File: rtl/v_hier_subdeser.sv
// Serial-to-word deserializer: LSB-first bits into WIDTH-bit words, queued in a DEPTH-entry FIFO.
// Optional even-parity bit after each word: define V_HIER_SUBDESER_PARITY_EN.
module v_hier_subdeser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     frame_start,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [WIDTH-1:0]         word_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     parity_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

`ifdef V_HIER_SUBDESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]  shreg, shreg_n, push_word;
  logic              push;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       lvl;
  logic              ovf;
  logic              pop, full, do_push;

`ifdef V_HIER_SUBDESER_PARITY_EN
  logic              perr, perr_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef V_HIER_SUBDESER_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
`ifdef V_HIER_SUBDESER_PARITY_EN
      perr  <= perr_n;
`endif
    end
  end

  // frame_start with a valid bit always restarts the word, regardless of state
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    push      = 1'b0;
    push_word = shreg;
`ifdef V_HIER_SUBDESER_PARITY_EN
    perr_n    = 1'b0;
`endif
    if (bit_valid) begin
      if (frame_start) begin
        shreg_n = WIDTH'(bit_in);
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end else begin
        unique case (state)
          IDLE: ;
          SHIFT: begin
            shreg_n[cnt] = bit_in;
            if (cnt == CW'(WIDTH-1)) begin
              cnt_n = '0;
`ifdef V_HIER_SUBDESER_PARITY_EN
              state_n = PAR;
`else
              push      = 1'b1;
              push_word = shreg_n;
`endif
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
`ifdef V_HIER_SUBDESER_PARITY_EN
          PAR: begin
            if (^{shreg, bit_in}) perr_n = 1'b1;
            else                  push   = 1'b1;
            state_n = SHIFT;
            cnt_n   = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    word_valid = (lvl != '0);
    pop        = word_valid && word_ready;
    full       = (lvl == FULL_LVL);
    do_push    = push && (!full || pop);
    word_data  = mem[rd_ptr];
    level      = lvl;
    overflow   = ovf;
`ifdef V_HIER_SUBDESER_PARITY_EN
    parity_err = perr;
`else
    parity_err = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      ovf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      lvl <= lvl + 1'b1;
      else if (pop && !do_push) lvl <= lvl - 1'b1;
      if (push && !do_push) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_v_hier_subdeser.sv
// Self-checking bench for v_hier_subdeser: vector table, directed corner cases, random run vs queue model.
module tb_v_hier_subdeser;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, bit_valid = 1'b0, bit_in = 1'b0, frame_start = 1'b0, word_ready = 1'b0;
  logic word_valid, overflow, parity_err;
  logic [WIDTH-1:0] word_data;
  logic [$clog2(DEPTH):0] level;

  int tests = 0;
  int fails = 0;

  v_hier_subdeser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .level(level), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // reference model state
  bit               m_bits[$];
  bit               m_active, m_inpar, m_ovf, m_perr;
  logic [WIDTH-1:0] m_word;
  logic [WIDTH-1:0] m_fifo[$];

  typedef struct {
    bit         bv, bi, fs, rdy;
    int         exp_level;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit bv, input bit bi, input bit fs, input bit rdy);
    bit pop, push;
    logic [WIDTH-1:0] pw;
    pop    = (m_fifo.size() != 0) && rdy;
    push   = 1'b0;
    pw     = '0;
    m_perr = 1'b0;
    if (r) begin
      m_bits.delete(); m_fifo.delete();
      m_active = 0; m_inpar = 0; m_ovf = 0;
      return;
    end
    if (bv) begin
      if (fs) begin
        m_bits.delete(); m_bits.push_back(bi);
        m_active = 1; m_inpar = 0;
      end else if (m_inpar) begin
        m_inpar = 0;
        if ((($countones(m_word) + int'(bi)) % 2) == 0) begin push = 1; pw = m_word; end
        else m_perr = 1;
      end else if (m_active) begin
        m_bits.push_back(bi);
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) pw[i] = m_bits[i];
          m_bits.delete();
`ifdef V_HIER_SUBDESER_PARITY_EN
          m_inpar = 1; m_word = pw;
`else
          push = 1;
`endif
        end
      end
    end
    if (push && m_fifo.size() == DEPTH && !pop) m_ovf = 1;
    if (pop) void'(m_fifo.pop_front());
    if (push && m_fifo.size() < DEPTH) m_fifo.push_back(pw);
  endtask

  task automatic step(input bit r, input bit bv, input bit bi, input bit fs, input bit rdy);
    rst = r; bit_valid = bv; bit_in = bi; frame_start = fs; word_ready = rdy;
    model_step(r, bv, bi, fs, rdy);
    @(posedge clk);
    #1;
    chk("m_valid", word_valid, m_fifo.size() != 0);
    chk("m_level", level, m_fifo.size());
    chk("m_ovf", overflow, m_ovf);
    chk("m_perr", parity_err, m_perr);
    if (m_fifo.size() != 0) chk("m_data", word_data, m_fifo[0]);
  endtask

  task automatic send_word(input logic [7:0] w, input bit fs, input bit rdy, input bit rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
`ifdef V_HIER_SUBDESER_PARITY_EN
      step(0, 1, w[i], fs && i == 0, rdy);
`else
      step(0, 1, w[i], fs && i == 0, (i == WIDTH-1) ? rdy_last : rdy);
`endif
    end
`ifdef V_HIER_SUBDESER_PARITY_EN
    step(0, 1, ^w, 0, rdy_last);
`endif
  endtask

  initial begin
    vec_t       tbl[$];
    vec_t       v;
    logic [7:0] a5 = 8'hA5;
    logic [7:0] exp4[4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    bit         r, bv, bi, fs, rdy;

    // word 0xA5 with consumer always ready
    for (int i = 0; i < WIDTH; i++) begin
      v.bv = 1; v.bi = a5[i]; v.fs = (i == 0); v.rdy = 1;
      v.exp_level = 0; v.exp_valid = 0; v.exp_data = 8'h00;
      tbl.push_back(v);
    end
`ifdef V_HIER_SUBDESER_PARITY_EN
    v.bv = 1; v.bi = 0; v.fs = 0; v.rdy = 1;
    tbl.push_back(v);
`endif
    tbl[tbl.size()-1].exp_level = 1;
    tbl[tbl.size()-1].exp_valid = 1;
    tbl[tbl.size()-1].exp_data  = 8'hA5;
    v.bv = 0; v.bi = 0; v.fs = 0; v.rdy = 1;
    v.exp_level = 0; v.exp_valid = 0; v.exp_data = 8'h00;
    tbl.push_back(v);

    // 1: reset held with active inputs
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 0);
      chk("rst_valid", word_valid, 0);
      chk("rst_data", word_data, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_perr", parity_err, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("rst_nopush", level, 0);

    // 2: vector table
    foreach (tbl[i]) begin
      step(0, tbl[i].bv, tbl[i].bi, tbl[i].fs, tbl[i].rdy);
      chk("vec_level", level, tbl[i].exp_level);
      chk("vec_valid", word_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("vec_data", word_data, tbl[i].exp_data);
    end

    // 3: overflow and ordered drain
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) send_word(8'(i), i == 1, 0, 0);
    chk("t3_level", level, 4);
    chk("t3_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", word_data, i + 1);
      step(0, 0, 0, 0, 1);
      chk("t3_ovf_sticky", overflow, 1);
    end
    chk("t3_empty", level, 0);

    // 4: push into full FIFO with simultaneous pop
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) send_word(8'(i), i == 1, 0, 0);
    chk("t4_full", level, 4);
    send_word(8'h06, 0, 0, 1);
    chk("t4_level", level, 4);
    chk("t4_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", word_data, exp4[i]);
      step(0, 0, 0, 0, 1);
    end
    chk("t4_empty", level, 0);

    // 5: partial word discarded by resync
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    send_word(8'h3C, 1, 1, 1);
    chk("t5_valid", word_valid, 1);
    chk("t5_data", word_data, 8'h3C);
    step(0, 0, 0, 0, 1);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 0);

`ifdef V_HIER_SUBDESER_PARITY_EN
    // 6: good and bad parity
    step(1, 0, 0, 0, 0);
    send_word(8'hA5, 1, 1, 1);
    chk("t6_good_valid", word_valid, 1);
    chk("t6_good_data", word_data, 8'hA5);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < WIDTH; i++) step(0, 1, a5[i], i == 0, 0);
    step(0, 1, 1, 0, 0);
    chk("t6_perr", parity_err, 1);
    chk("t6_level", level, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_perr_clear", parity_err, 0);
`endif

    // random run against the model
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      bv  = ($urandom_range(0, 9) < 7);
      bi  = 1'($urandom_range(0, 1));
      fs  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      step(r, bv, bi, fs, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
